// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the instruction fetch sequencer: the fetch FSM state
// encoding, the architectural reset vector, the instruction size and a helper
// that forces an address onto a word boundary.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,   // presenting a fetch request to instruction memory
        WAIT = 2'd1,   // one request outstanding, waiting for its response
        HOLD = 2'd2    // instruction held for decode
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] INSTR_BYTES  = 32'd4;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~(INSTR_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Sequences instruction fetches: issues one request at a time to instruction
// memory, captures the returned word with its address, and holds it for the
// decode stage until it is accepted. A redirect (taken branch/jump) replaces
// the fetch PC in any state and discards whatever is in flight or held.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   imem_req_valid    fetch request valid (out)
//   imem_req_ready    memory accepts request (in)
//   imem_req_addr     word-aligned fetch address (out)
//   imem_resp_valid   instruction data valid (in)
//   imem_resp_data    fetched instruction word (in)
//   redirect_valid    redirect request (in)
//   redirect_pc       redirect target, bits [1:0] ignored (in)
//   if_valid          instruction available to decode (out)
//   if_ready          decode accepts instruction (in)
//   if_pc             address of if_instr (out)
//   if_instr          held instruction word (out)
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  redirect_aligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            if_pc_q    <= 32'd0;
            if_instr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        drop_d           = drop_q;
        if_pc_d          = if_pc_q;
        if_instr_d       = if_instr_q;
        imem_req_valid   = 1'b0;
        if_valid         = 1'b0;
        redirect_aligned = align_word(redirect_pc);

        case (state_q)
            REQ: begin
                // rst_n gating keeps the request low while reset is held,
                // since the state register already sits in REQ then.
                imem_req_valid = rst_n && !redirect_valid;
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                end else if (imem_req_valid && imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                    if (imem_resp_valid) begin
                        // The coinciding response is stale; nothing left in flight.
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        // Request still outstanding: swallow its response later.
                        drop_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q) begin
                        state_d = REQ;
                    end else begin
                        if_pc_d    = pc_q;
                        if_instr_d = imem_resp_data;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if_valid = !redirect_valid;
                if (redirect_valid) begin
                    pc_d    = redirect_aligned;
                    state_d = REQ;
                end else if (if_ready) begin
                    pc_d    = pc_q + INSTR_BYTES;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    assign imem_req_addr = pc_q;
    assign if_pc         = if_pc_q;
    assign if_instr      = if_instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. Inputs change 1 time unit after each
// rising edge; outputs are checked 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int errors;
    int checks;

    fetch_sequencer #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full fetch: accept, 1-cycle response, decode handshake. Entered and
    // left 1 unit after a rising edge with the FSM in REQ.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; if_ready = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== addr) begin
            errors++;
            $display("FAIL fetch_req: valid=%b addr=%h, want valid=1 addr=%h", imem_req_valid, imem_req_addr, addr);
        end
        next_cycle();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = data;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: req_valid=%b if_valid=%b, want 0 0", imem_req_valid, if_valid);
        end
        next_cycle();
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0; if_ready = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== addr || if_instr !== data || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_hold: if_valid=%b pc=%h instr=%h req=%b, want 1 %h %h 0", if_valid, if_pc, if_instr, imem_req_valid, addr, data);
        end
        next_cycle();
        if_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: req_valid=%b if_valid=%b, want 0 0", imem_req_valid, if_valid);
        end
        checks++;
        if (if_pc !== 32'h0 || if_instr !== 32'h0 || imem_req_addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL reset_regs: if_pc=%h if_instr=%h addr=%h, want 0 0 bfc00000", if_pc, if_instr, imem_req_addr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL reset_first_req: valid=%b addr=%h, want 1 bfc00000", imem_req_valid, imem_req_addr);
        end
        next_cycle();
    endtask

    task automatic test_sequential();
        fetch_one(32'hBFC0_0000, 32'h1111_1111);
        fetch_one(32'hBFC0_0004, 32'h2222_2222);
        fetch_one(32'hBFC0_0008, 32'h3333_3333);
    endtask

    task automatic test_stall();
        imem_req_ready = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hBFC0_000C) begin
            errors++;
            $display("FAIL stall_req: valid=%b addr=%h, want 1 bfc0000c", imem_req_valid, imem_req_addr);
        end
        next_cycle();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_F00D;
        next_cycle();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // Stray responses while holding must not disturb the held word.
            imem_resp_valid = i[0]; imem_resp_data = 32'h0BAD_0000 + i;
            #1;
            checks++;
            if (if_valid !== 1'b1 || if_instr !== 32'hCAFE_F00D || if_pc !== 32'hBFC0_000C || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: if_valid=%b instr=%h pc=%h req=%b, want 1 cafef00d bfc0000c 0", i, if_valid, if_instr, if_pc, imem_req_valid);
            end
            next_cycle();
        end
        imem_resp_valid = 1'b0; if_ready = 1'b1;
        next_cycle();
        if_ready = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hBFC0_0010 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_advance: valid=%b addr=%h if_valid=%b, want 1 bfc00010 0", imem_req_valid, imem_req_addr, if_valid);
        end
        next_cycle();
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        next_cycle();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0013;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdw_redirect: req=%b if_valid=%b, want 0 0", imem_req_valid, if_valid);
        end
        next_cycle();
        redirect_valid = 1'b0;
        next_cycle();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdw_resp: if_valid=%b req=%b, want 0 0", if_valid, imem_req_valid);
        end
        next_cycle();
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rdw_discard: if_valid=%b instr=%h, want 0 cafef00d", if_valid, if_instr);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0040_0010) begin
            errors++;
            $display("FAIL rdw_target: valid=%b addr=%h, want 1 00400010", imem_req_valid, imem_req_addr);
        end
        fetch_one(32'h0040_0010, 32'h4444_4444);
    endtask

    task automatic test_redirect_hold();
        imem_req_ready = 1'b1;
        next_cycle();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h5555_5555;
        next_cycle();
        imem_resp_valid = 1'b0; if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
        #1;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdh_if_valid: if_valid=%b, want 0", if_valid);
        end
        next_cycle();
        if_ready = 1'b0; redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL rdh_target: valid=%b addr=%h, want 1 00001000", imem_req_valid, imem_req_addr);
        end
        // Redirect while requesting suppresses the request that cycle.
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdr_suppress: valid=%b, want 0", imem_req_valid);
        end
        next_cycle();
        redirect_valid = 1'b0; imem_req_ready = 1'b0;
    endtask

    task automatic test_wrap();
        fetch_one(32'hFFFF_FFFC, 32'h6666_6666);
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_addr: valid=%b addr=%h, want 1 00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_with_resp();
        imem_req_ready = 1'b1;
        next_cycle();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h7777_7777;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0101;
        next_cycle();
        imem_resp_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100 || if_instr !== 32'h6666_6666) begin
            errors++;
            $display("FAIL rwr: if_valid=%b req=%b addr=%h instr=%h, want 0 1 00000100 66666666", if_valid, imem_req_valid, imem_req_addr, if_instr);
        end
    endtask

    task automatic test_reset_mid_wait();
        imem_req_ready = 1'b1;
        next_cycle();
        imem_req_ready = 1'b0; rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_instr !== 32'h0) begin
            errors++;
            $display("FAIL rmw_in_reset: req=%b if_valid=%b instr=%h, want 0 0 0", imem_req_valid, if_valid, if_instr);
        end
        next_cycle();
        rst_n = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'h8888_8888;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL rmw_release: valid=%b addr=%h, want 1 bfc00000", imem_req_valid, imem_req_addr);
        end
        next_cycle();
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'h0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL rmw_stray: if_valid=%b instr=%h req=%b addr=%h, want 0 0 1 bfc00000", if_valid, if_instr, imem_req_valid, imem_req_addr);
        end
        fetch_one(32'hBFC0_0000, 32'h9999_9999);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        if_ready = 1'b0;
        next_cycle();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_redirect_with_resp();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
